// File: rtl/a2d_spi_multich_if.sv
// SPI bus between the A2D interface master and the bench-side A2D converter model.
interface a2d_spi_multich_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_spi_multich_model.sv
// N-channel SPI A2D converter model: 16-bit frames, channel code in command bits [13:11],
// result of frame N is the channel commanded in frame N-1. Optional droop ramp: A2D_RAMP_EN.
module a2d_spi_multich_model #(
    parameter int NUM_CH    = 8,
    parameter int RES       = 12,
    parameter int RAMP_STEP = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    a2d_spi_multich_if.slave      spi,
    input  logic [NUM_CH*RES-1:0] ch_data,
    output logic [2:0]            cur_ch,
    output logic                  frame_done,
    output logic [7:0]            bad_ch_cnt,
    output logic [7:0]            short_cnt
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    localparam logic [3:0] NUM_CH_W = 4'(NUM_CH);

    state_t      state_reg, state_next;
    logic [4:0]  bit_cnt_reg, bit_cnt_next;
    logic [15:0] tx_shft_reg, tx_shft_next;
    logic [13:0] rx_shft_reg, rx_shft_next;
    logic [2:0]  cur_ch_reg, cur_ch_next;
    logic [7:0]  bad_cnt_reg, bad_cnt_next;
    logic [7:0]  short_cnt_reg, short_cnt_next;
    logic        frame_done_reg, frame_done_next;
    logic        frame_cmpl;

    // Synchronisers; the third SS_n/SCLK stage is the edge-detect history.
    logic [2:0] ss_sync_reg, sclk_sync_reg;
    logic [1:0] mosi_sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync_reg   <= 3'b111;
            sclk_sync_reg <= 3'b000;
            mosi_sync_reg <= 2'b00;
        end else begin
            ss_sync_reg   <= {ss_sync_reg[1:0], spi.SS_n};
            sclk_sync_reg <= {sclk_sync_reg[1:0], spi.SCLK};
            mosi_sync_reg <= {mosi_sync_reg[0], spi.MOSI};
        end
    end

    logic ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;
    assign ss_fall   =  ss_sync_reg[2]   & ~ss_sync_reg[1];
    assign ss_rise   = ~ss_sync_reg[2]   &  ss_sync_reg[1];
    assign sclk_rise = ~sclk_sync_reg[2] &  sclk_sync_reg[1];
    assign sclk_fall =  sclk_sync_reg[2] & ~sclk_sync_reg[1];
    assign mosi_s    =  mosi_sync_reg[1];

    // Eight-entry lookup so any 3-bit channel code indexes safely; absent channels read 0.
    logic [15:0] raw_val [8];
    logic [15:0] ret_val [8];

`ifdef A2D_RAMP_EN
    logic [2:0] ret_ch_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ret_ch_reg <= '0;
        else if (state_reg == IDLE && ss_fall)
            ret_ch_reg <= cur_ch_reg;
    end
`endif

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_ch
            if (gi < NUM_CH) begin : g_valid
                assign raw_val[gi] = 16'(ch_data[gi*RES +: RES]);
            end else begin : g_absent
                assign raw_val[gi] = '0;
            end
`ifdef A2D_RAMP_EN
            logic [15:0] offset_reg;
            logic        tog_reg;

            // Offset steps on every second completed frame that returned this channel.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    offset_reg <= '0;
                    tog_reg    <= 1'b0;
                end else if (frame_cmpl && ret_ch_reg == 3'(gi)) begin
                    tog_reg <= ~tog_reg;
                    if (tog_reg)
                        offset_reg <= (offset_reg > 16'hFFFF - 16'(RAMP_STEP)) ?
                                      16'hFFFF : offset_reg + 16'(RAMP_STEP);
                end
            end

            assign ret_val[gi] = (raw_val[gi] > offset_reg) ? raw_val[gi] - offset_reg : '0;
`else
            assign ret_val[gi] = raw_val[gi];
`endif
        end
    endgenerate

`ifndef A2D_RAMP_EN
    logic [31:0] unused_ramp_step;
    assign unused_ramp_step = 32'(RAMP_STEP);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            tx_shft_reg    <= '0;
            rx_shft_reg    <= '0;
            cur_ch_reg     <= '0;
            bad_cnt_reg    <= '0;
            short_cnt_reg  <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            tx_shft_reg    <= tx_shft_next;
            rx_shft_reg    <= rx_shft_next;
            cur_ch_reg     <= cur_ch_next;
            bad_cnt_reg    <= bad_cnt_next;
            short_cnt_reg  <= short_cnt_next;
            frame_done_reg <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        tx_shft_next    = tx_shft_reg;
        rx_shft_next    = rx_shft_reg;
        cur_ch_next     = cur_ch_reg;
        bad_cnt_next    = bad_cnt_reg;
        short_cnt_next  = short_cnt_reg;
        frame_done_next = 1'b0;
        frame_cmpl      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (ss_fall) begin
                    tx_shft_next = ret_val[cur_ch_reg];
                    bit_cnt_next = '0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_reg == 5'd16) begin
                    state_next = HOLD;
                    frame_cmpl = ss_rise;
                end else if (ss_rise) begin
                    if (short_cnt_reg != 8'hFF)
                        short_cnt_next = short_cnt_reg + 8'd1;
                    state_next = IDLE;
                end else begin
                    if (sclk_rise) begin
                        rx_shft_next = {rx_shft_reg[12:0], mosi_s};
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                    end
                    if (sclk_fall)
                        tx_shft_next = {tx_shft_reg[14:0], 1'b0};
                end
            end
            HOLD: begin
                frame_cmpl = ss_rise;
            end
            default: state_next = IDLE;
        endcase

        // After 16 shifts the command's channel field sits at rx_shft[13:11].
        if (frame_cmpl) begin
            frame_done_next = 1'b1;
            cur_ch_next     = rx_shft_reg[13:11];
            if ({1'b0, rx_shft_reg[13:11]} >= NUM_CH_W && bad_cnt_reg != 8'hFF)
                bad_cnt_next = bad_cnt_reg + 8'd1;
            state_next = IDLE;
        end
    end

    assign spi.MISO   = (state_reg != IDLE) && tx_shft_reg[15];
    assign cur_ch     = cur_ch_reg;
    assign frame_done = frame_done_reg;
    assign bad_ch_cnt = bad_cnt_reg;
    assign short_cnt  = short_cnt_reg;
endmodule

// File: tb/tb_a2d_spi_multich_model.sv
// Bench for a2d_spi_multich_model: a default (8 ch, 12 bit) and a narrow (6 ch, 10 bit) instance.
module tb_a2d_spi_multich_model;
    localparam int STEP = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    a2d_spi_multich_if spi0();
    a2d_spi_multich_if spi1();

    logic        ss_n [2];
    logic        sclk [2];
    logic        mosi [2];
    logic        miso [2];
    logic [95:0] ch_data0;
    logic [59:0] ch_data1;
    logic [2:0]  cur_ch [2];
    logic        fd [2];
    logic [7:0]  bad [2];
    logic [7:0]  shrt [2];

    assign spi0.SS_n = ss_n[0];
    assign spi0.SCLK = sclk[0];
    assign spi0.MOSI = mosi[0];
    assign miso[0]   = spi0.MISO;
    assign spi1.SS_n = ss_n[1];
    assign spi1.SCLK = sclk[1];
    assign spi1.MOSI = mosi[1];
    assign miso[1]   = spi1.MISO;

    a2d_spi_multich_model #(.NUM_CH(8), .RES(12), .RAMP_STEP(STEP)) dut0 (
        .clk(clk), .rst_n(rst_n), .spi(spi0), .ch_data(ch_data0),
        .cur_ch(cur_ch[0]), .frame_done(fd[0]), .bad_ch_cnt(bad[0]), .short_cnt(shrt[0])
    );

    a2d_spi_multich_model #(.NUM_CH(6), .RES(10), .RAMP_STEP(STEP)) dut1 (
        .clk(clk), .rst_n(rst_n), .spi(spi1), .ch_data(ch_data1),
        .cur_ch(cur_ch[1]), .frame_done(fd[1]), .bad_ch_cnt(bad[1]), .short_cnt(shrt[1])
    );

    int checks = 0;
    int errors = 0;
    int fd_cnt [2] = '{0, 0};
    logic [15:0] exp_q [$];

    // Reference model state
    int          numch [2] = '{8, 6};
    logic [2:0]  m_cur [2];
    logic [7:0]  m_bad [2];
    logic [7:0]  m_short [2];
    logic [15:0] m_off [2][8];
    logic        m_tog [2][8];

    always @(posedge clk)
        for (int d = 0; d < 2; d++)
            if (fd[d] === 1'b1) fd_cnt[d]++;

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cur[d] = '0; m_bad[d] = '0; m_short[d] = '0;
            for (int c = 0; c < 8; c++) begin
                m_off[d][c] = '0; m_tog[d][c] = 1'b0;
            end
        end
    endtask

    function automatic logic [15:0] model_ret(input int d);
        logic [15:0] raw;
        int ch;
        ch = int'(m_cur[d]);
        raw = '0;
        if (ch < numch[d])
            raw = (d == 0) ? 16'(ch_data0[ch*12 +: 12]) : 16'(ch_data1[ch*10 +: 10]);
`ifdef A2D_RAMP_EN
        raw = (raw > m_off[d][ch]) ? raw - m_off[d][ch] : 16'h0000;
`endif
        return raw;
    endfunction

    task automatic model_complete(input int d, input logic [15:0] cmd);
`ifdef A2D_RAMP_EN
        int ch;
        ch = int'(m_cur[d]);
        if (m_tog[d][ch]) m_off[d][ch] = m_off[d][ch] + 16'(STEP);
        m_tog[d][ch] = ~m_tog[d][ch];
`endif
        m_cur[d] = cmd[13:11];
        if (int'(cmd[13:11]) >= numch[d] && m_bad[d] != 8'hFF) m_bad[d]++;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ss_n[d] = 1'b1; sclk[d] = 1'b0; mosi[d] = 1'b0;
        end
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
        model_reset();
    endtask

    // Drives one frame of nbits; full frames push the model's expected word onto exp_q.
    task automatic spi_frame(input int d, input logic [15:0] cmd, input int nbits,
                             input bit scramble, output logic [15:0] rx, output int fd_delta);
        int fd_before;
        fd_before = fd_cnt[d];
        ss_n[d] = 1'b0;
        if (nbits == 16) exp_q.push_back(model_ret(d));
        wait_clk(8);
        if (scramble) begin
            ch_data0 = {$urandom, $urandom, $urandom};
            ch_data1 = {$urandom, $urandom};
        end
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi[d] = cmd[15-i];
            wait_clk(4);
            rx = {rx[14:0], miso[d]};
            sclk[d] = 1'b1;
            wait_clk(8);
            sclk[d] = 1'b0;
            wait_clk(4);
        end
        mosi[d] = 1'b0;
        ss_n[d] = 1'b1;
        wait_clk(8);
        if (nbits == 16) model_complete(d, cmd);
        else if (m_short[d] != 8'hFF) m_short[d]++;
        fd_delta = fd_cnt[d] - fd_before;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int d = 0; d < 2; d++) begin
            checks++; if (miso[d] !== 1'b0) begin errors++; $display("FAIL reset_miso[%0d]: got %b want 0", d, miso[d]); end
            checks++; if (cur_ch[d] !== 3'd0) begin errors++; $display("FAIL reset_cur_ch[%0d]: got %0d want 0", d, cur_ch[d]); end
            checks++; if (fd[d] !== 1'b0) begin errors++; $display("FAIL reset_frame_done[%0d]: got %b want 0", d, fd[d]); end
            checks++; if (bad[d] !== 8'd0) begin errors++; $display("FAIL reset_bad_cnt[%0d]: got %0d want 0", d, bad[d]); end
            checks++; if (shrt[d] !== 8'd0) begin errors++; $display("FAIL reset_short_cnt[%0d]: got %0d want 0", d, shrt[d]); end
        end
        $display("reset: checked idle state of both instances");
    endtask

    task automatic test_basic();
        logic [15:0] rx, exp;
        int fdd;
        ch_data0 = {$urandom, $urandom, $urandom};
        ch_data0[0*12 +: 12] = 12'h123;
        ch_data0[4*12 +: 12] = 12'hABC;
        spi_frame(0, 16'h2000, 16, 1'b0, rx, fdd);
        exp = exp_q.pop_front();
        $display("frame dut0 cmd=2000 rx=%04h exp=%04h", rx, exp);
        checks++; if (rx !== exp || rx !== 16'h0123) begin errors++; $display("FAIL basic_frame0: got %04h want %04h", rx, exp); end
        checks++; if (fdd !== 1) begin errors++; $display("FAIL basic_frame_done0: got %0d pulses want 1", fdd); end
        checks++; if (cur_ch[0] !== 3'd4) begin errors++; $display("FAIL basic_cur_ch0: got %0d want 4", cur_ch[0]); end
        spi_frame(0, 16'h2800, 16, 1'b0, rx, fdd);
        exp = exp_q.pop_front();
        $display("frame dut0 cmd=2800 rx=%04h exp=%04h", rx, exp);
        checks++; if (rx !== exp || rx !== 16'h0ABC) begin errors++; $display("FAIL basic_frame1: got %04h want %04h", rx, exp); end
        checks++; if (cur_ch[0] !== 3'd5) begin errors++; $display("FAIL basic_cur_ch1: got %0d want 5", cur_ch[0]); end
    endtask

    task automatic test_bad_channel();
        logic [15:0] rx, exp;
        int fdd;
        ch_data1 = {$urandom, $urandom};
        ch_data1[0 +: 10] = 10'h3FF;
        spi_frame(1, 16'h3800, 16, 1'b0, rx, fdd);
        exp = exp_q.pop_front();
        $display("frame dut1 cmd=3800 rx=%04h exp=%04h", rx, exp);
        checks++; if (rx !== exp || rx !== 16'h03FF) begin errors++; $display("FAIL res10_frame: got %04h want %04h", rx, exp); end
        checks++; if (cur_ch[1] !== 3'd7) begin errors++; $display("FAIL bad_cur_ch: got %0d want 7", cur_ch[1]); end
        spi_frame(1, 16'h0000, 16, 1'b0, rx, fdd);
        exp = exp_q.pop_front();
        $display("frame dut1 cmd=0000 rx=%04h exp=%04h", rx, exp);
        checks++; if (rx !== exp || rx !== 16'h0000) begin errors++; $display("FAIL bad_ch_data: got %04h want %04h", rx, exp); end
        checks++; if (bad[1] !== m_bad[1] || bad[1] !== 8'd1) begin errors++; $display("FAIL bad_ch_cnt: got %0d want %0d", bad[1], m_bad[1]); end
        checks++; if (bad[0] !== 8'd0) begin errors++; $display("FAIL bad_ch_cnt_dut0: got %0d want 0", bad[0]); end
    endtask

    task automatic test_short_frame();
        logic [15:0] rx, exp;
        int fdd;
        spi_frame(0, 16'h1000, 9, 1'b0, rx, fdd);
        $display("short frame dut0 9 bits short_cnt=%0d cur_ch=%0d", shrt[0], cur_ch[0]);
        checks++; if (fdd !== 0) begin errors++; $display("FAIL short_frame_done: got %0d pulses want 0", fdd); end
        checks++; if (shrt[0] !== m_short[0] || shrt[0] !== 8'd1) begin errors++; $display("FAIL short_cnt: got %0d want %0d", shrt[0], m_short[0]); end
        checks++; if (cur_ch[0] !== m_cur[0] || cur_ch[0] !== 3'd5) begin errors++; $display("FAIL short_cur_ch: got %0d want %0d", cur_ch[0], m_cur[0]); end
        spi_frame(0, 16'h0800, 16, 1'b0, rx, fdd);
        exp = exp_q.pop_front();
        $display("frame dut0 cmd=0800 rx=%04h exp=%04h", rx, exp);
        checks++; if (rx !== exp) begin errors++; $display("FAIL short_followup: got %04h want %04h", rx, exp); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rx, exp, cmd;
        int fdd, d;
        for (int n = 0; n < 12; n++) begin
            d = n % 2;
            cmd = 16'($urandom);
            spi_frame(d, cmd, 16, 1'b1, rx, fdd);
            exp = exp_q.pop_front();
            $display("frame dut%0d cmd=%04h rx=%04h exp=%04h", d, cmd, rx, exp);
            checks++; if (rx !== exp) begin errors++; $display("FAIL b2b_data[%0d]: got %04h want %04h", n, rx, exp); end
            checks++; if (cur_ch[d] !== m_cur[d]) begin errors++; $display("FAIL b2b_cur_ch[%0d]: got %0d want %0d", n, cur_ch[d], m_cur[d]); end
            checks++; if (bad[d] !== m_bad[d]) begin errors++; $display("FAIL b2b_bad_cnt[%0d]: got %0d want %0d", n, bad[d], m_bad[d]); end
            checks++; if (fdd !== 1) begin errors++; $display("FAIL b2b_frame_done[%0d]: got %0d want 1", n, fdd); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] rx, exp;
        int fdd, fd_before;
        fd_before = fd_cnt[0];
        ss_n[0] = 1'b0;
        wait_clk(8);
        for (int i = 0; i < 5; i++) begin
            mosi[0] = 1'b1; wait_clk(4); sclk[0] = 1'b1; wait_clk(8); sclk[0] = 1'b0; wait_clk(4);
        end
        rst_n = 1'b0;
        wait_clk(2);
        checks++; if (miso[0] !== 1'b0) begin errors++; $display("FAIL midreset_miso: got %b want 0", miso[0]); end
        ss_n[0] = 1'b1; mosi[0] = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(6);
        model_reset();
        $display("reset mid-frame dut0 short_cnt=%0d cur_ch=%0d", shrt[0], cur_ch[0]);
        checks++; if (shrt[0] !== 8'd0) begin errors++; $display("FAIL midreset_short_cnt: got %0d want 0", shrt[0]); end
        checks++; if (fd_cnt[0] !== fd_before) begin errors++; $display("FAIL midreset_frame_done: got %0d pulses want 0", fd_cnt[0] - fd_before); end
        spi_frame(0, 16'h0000, 16, 1'b0, rx, fdd);
        exp = exp_q.pop_front();
        $display("frame dut0 cmd=0000 rx=%04h exp=%04h", rx, exp);
        checks++; if (rx !== exp) begin errors++; $display("FAIL midreset_followup: got %04h want %04h", rx, exp); end
    endtask

    task automatic test_ramp();
        logic [15:0] rx, exp;
        logic [15:0] seq [6];
        int fdd;
`ifdef A2D_RAMP_EN
        seq = '{16'h0C00, 16'h0C00, 16'h0BF0, 16'h0BF0, 16'h0BE0, 16'h0BE0};
`else
        seq = '{16'h0C00, 16'h0C00, 16'h0C00, 16'h0C00, 16'h0C00, 16'h0C00};
`endif
        apply_reset();
        ch_data0[0 +: 12] = 12'hC00;
        for (int n = 0; n < 6; n++) begin
            spi_frame(0, 16'h0000, 16, 1'b0, rx, fdd);
            exp = exp_q.pop_front();
            $display("ramp frame %0d rx=%04h exp=%04h", n, rx, exp);
            checks++; if (rx !== exp || rx !== seq[n]) begin errors++; $display("FAIL ramp[%0d]: got %04h want %04h", n, rx, seq[n]); end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            ss_n[d] = 1'b1; sclk[d] = 1'b0; mosi[d] = 1'b0;
        end
        ch_data0 = '0;
        ch_data1 = '0;
        model_reset();
        test_reset();
        test_basic();
        test_bad_channel();
        test_short_frame();
        test_back_to_back();
        test_reset_midframe();
        test_ramp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
